// File: rtl/csr_pkg.sv
// Shared CSR definitions: address map, mstatus bit positions, CSR funct3
// encodings (also used by the write-data generator) and address decode helpers.
package csr_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;

  // mtvec and mepc are word aligned; the low two bits always read zero.
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    Funct3Csrrw  = 3'b001,
    Funct3Csrrs  = 3'b010,
    Funct3Csrrc  = 3'b011,
    Funct3Csrrwi = 3'b101,
    Funct3Csrrsi = 3'b110,
    Funct3Csrrci = 3'b111
  } csr_funct3_e;

  function automatic logic csr_is_known(logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
      CSR_MTVAL, CSR_MCYCLE, CSR_MINSTRET, CSR_MCYCLEH, CSR_MINSTRETH, CSR_CYCLE,
      CSR_INSTRET, CSR_CYCLEH, CSR_INSTRETH, CSR_MHARTID: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Address bits [11:10] == 2'b11 mark the read-only CSR space.
  function automatic logic csr_is_read_only(logic [11:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/csr_file_if.sv
// CSR access port between the execute stage (master) and csr_file (slave).
//   csr_addr    : CSR address of the current instruction
//   csr_we      : commit csr_w_data at the next rising edge
//   csr_w_data  : value from the CSR write-data generator
//   csr_r_data  : combinational read of csr_addr
//   illegal_csr : unknown address, or write to read-only space
interface csr_file_if;
  import csr_pkg::*;

  logic [11:0]     csr_addr;
  logic            csr_we;
  logic [XLEN-1:0] csr_w_data;
  logic [XLEN-1:0] csr_r_data;
  logic            illegal_csr;

  modport master (
    output csr_addr, csr_we, csr_w_data,
    input  csr_r_data, illegal_csr
  );

  modport slave (
    input  csr_addr, csr_we, csr_w_data,
    output csr_r_data, illegal_csr
  );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independently writable 32-bit halves.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : increment by one this cycle
//   we_lo/hi   : load the low/high half from wdata (suppresses increment)
//   wdata      : load value
//   count      : current 64-bit value
module csr_counter64
  import csr_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            we_lo,
  input  logic            we_hi,
  input  logic [XLEN-1:0] wdata,
  output logic [63:0]     count
);

  logic [63:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    // A half write holds the other half untouched: no increment, no carry.
    if (we_lo) begin
      count_d[31:0] = wdata;
    end else if (we_hi) begin
      count_d[63:32] = wdata;
    end else if (inc) begin
      count_d = count_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file for the single-hart RV32 core.
//   clk, rst_n            : clock, asynchronous active-low reset
//   bus                   : CSR access port (address, write, read data, illegal flag)
//   instret_inc           : one instruction retired this cycle
//   trap_en/cause/pc/val  : trap entry and the values it records
//   mret_en               : execute MRET this cycle
//   trap_vector, epc      : mtvec base and mepc for the fetch unit
//   irq_enable            : mstatus.MIE
module csr_file
  import csr_pkg::*;
#(
  parameter logic [XLEN-1:0] HART_ID  = '0,
  parameter logic [XLEN-1:0] MISA_VAL = 32'h4000_0100
) (
  input  logic            clk,
  input  logic            rst_n,
  csr_file_if.slave       bus,
  input  logic            instret_inc,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_val,
  input  logic            mret_en,
  output logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] epc,
  output logic            irq_enable
);

  logic            mstatus_mie_q, mstatus_mie_d;
  logic            mstatus_mpie_q, mstatus_mpie_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [63:0]     mcycle, minstret;
  logic [XLEN-1:0] mstatus_rd;
  logic            csr_wr;

  assign bus.illegal_csr = !csr_is_known(bus.csr_addr) ||
                           (bus.csr_we && csr_is_read_only(bus.csr_addr));
  assign csr_wr = bus.csr_we && !bus.illegal_csr;

  always_comb begin
    mstatus_rd               = '0;
    mstatus_rd[MSTATUS_MIE]  = mstatus_mie_q;
    mstatus_rd[MSTATUS_MPIE] = mstatus_mpie_q;
    mstatus_rd[12:11]        = 2'b11;  // MPP: machine mode only
  end

  always_comb begin
    bus.csr_r_data = '0;
    case (bus.csr_addr)
      CSR_MSTATUS:               bus.csr_r_data = mstatus_rd;
      CSR_MISA:                  bus.csr_r_data = MISA_VAL;
      CSR_MIE:                   bus.csr_r_data = mie_q;
      CSR_MTVEC:                 bus.csr_r_data = mtvec_q;
      CSR_MSCRATCH:              bus.csr_r_data = mscratch_q;
      CSR_MEPC:                  bus.csr_r_data = mepc_q;
      CSR_MCAUSE:                bus.csr_r_data = mcause_q;
      CSR_MTVAL:                 bus.csr_r_data = mtval_q;
      CSR_MCYCLE, CSR_CYCLE:     bus.csr_r_data = mcycle[31:0];
      CSR_MCYCLEH, CSR_CYCLEH:   bus.csr_r_data = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET: bus.csr_r_data = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: bus.csr_r_data = minstret[63:32];
      CSR_MHARTID:               bus.csr_r_data = HART_ID;
      default:                   bus.csr_r_data = '0;
    endcase
  end

  // Software write first; trap, then MRET, override whatever bits they own so a
  // colliding write is dropped while writes to unrelated CSRs still land.
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;

    if (csr_wr) begin
      case (bus.csr_addr)
        CSR_MSTATUS: begin
          mstatus_mie_d  = bus.csr_w_data[MSTATUS_MIE];
          mstatus_mpie_d = bus.csr_w_data[MSTATUS_MPIE];
        end
        CSR_MIE:      mie_d      = bus.csr_w_data;
        CSR_MTVEC:    mtvec_d    = bus.csr_w_data & ALIGN_MASK;
        CSR_MSCRATCH: mscratch_d = bus.csr_w_data;
        CSR_MEPC:     mepc_d     = bus.csr_w_data & ALIGN_MASK;
        CSR_MCAUSE:   mcause_d   = bus.csr_w_data;
        CSR_MTVAL:    mtval_d    = bus.csr_w_data;
        default: ;
      endcase
    end

    if (trap_en) begin
      mepc_d         = trap_pc & ALIGN_MASK;
      mcause_d       = trap_cause;
      mtval_d        = trap_val;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret_en) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= '0;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
    end
  end

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .we_lo (csr_wr && (bus.csr_addr == CSR_MCYCLE)),
    .we_hi (csr_wr && (bus.csr_addr == CSR_MCYCLEH)),
    .wdata (bus.csr_w_data),
    .count (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (instret_inc),
    .we_lo (csr_wr && (bus.csr_addr == CSR_MINSTRET)),
    .we_hi (csr_wr && (bus.csr_addr == CSR_MINSTRETH)),
    .wdata (bus.csr_w_data),
    .count (minstret)
  );

  assign trap_vector = mtvec_q;
  assign epc         = mepc_q;
  assign irq_enable  = mstatus_mie_q;

endmodule

// File: tb/tb_csr_file.sv
module tb_csr_file;
  import csr_pkg::*;

  localparam logic [31:0] TB_HART = 32'h0000_0005;
  localparam logic [31:0] TB_MISA = 32'h4000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instret_inc, trap_en, mret_en;
  logic [31:0] trap_cause, trap_pc, trap_val;
  logic [31:0] trap_vector, epc;
  logic        irq_enable;

  int passes = 0;
  int checks = 0;

  always #5 clk = ~clk;

  csr_file_if bus ();

  csr_file #(.HART_ID(TB_HART), .MISA_VAL(TB_MISA)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .instret_inc (instret_inc),
    .trap_en     (trap_en),
    .trap_cause  (trap_cause),
    .trap_pc     (trap_pc),
    .trap_val    (trap_val),
    .mret_en     (mret_en),
    .trap_vector (trap_vector),
    .epc         (epc),
    .irq_enable  (irq_enable)
  );

  // ---------------- reference model (architectural view) ----------------
  bit          m_mie, m_mpie;
  logic [31:0] m_mie_reg, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cycle, m_instret;

  logic [11:0] known_list [17] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                   12'h342, 12'h343, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                                   12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF14};

  function automatic bit m_known(input logic [11:0] a);
    foreach (known_list[i]) if (known_list[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_illegal(input logic [11:0] a, input logic we);
    return !m_known(a) || (we && a >= 12'hC00);
  endfunction

  // mtvec/mepc keep the raw value; alignment is applied on observation.
  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 + (m_mie ? 32'h8 : 32'h0) + (m_mpie ? 32'h80 : 32'h0);
      12'h301: return TB_MISA;
      12'h304: return m_mie_reg;
      12'h305: return m_mtvec & 32'hFFFF_FFFC;
      12'h340: return m_mscratch;
      12'h341: return m_mepc & 32'hFFFF_FFFC;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'hB00, 12'hC00: return m_cycle[31:0];
      12'hB80, 12'hC80: return m_cycle[63:32];
      12'hB02, 12'hC02: return m_instret[31:0];
      12'hB82, 12'hC82: return m_instret[63:32];
      12'hF14: return TB_HART;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_mie = 0; m_mpie = 0;
    m_mie_reg = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    m_cycle = 0; m_instret = 0;
  endtask

  task automatic model_step();
    bit          old_mie, old_mpie, wr;
    logic [11:0] a;
    logic [31:0] w;
    old_mie = m_mie; old_mpie = m_mpie;
    a = bus.csr_addr; w = bus.csr_w_data;
    wr = bus.csr_we && !m_illegal(a, bus.csr_we);
    if (wr && a == 12'hB00) m_cycle[31:0] = w;
    else if (wr && a == 12'hB80) m_cycle[63:32] = w;
    else m_cycle = m_cycle + 1;
    if (wr && a == 12'hB02) m_instret[31:0] = w;
    else if (wr && a == 12'hB82) m_instret[63:32] = w;
    else if (instret_inc) m_instret = m_instret + 1;
    if (wr) begin
      case (a)
        12'h300: begin m_mie = w[3]; m_mpie = w[7]; end
        12'h304: m_mie_reg = w;
        12'h305: m_mtvec = w;
        12'h340: m_mscratch = w;
        12'h341: m_mepc = w;
        12'h342: m_mcause = w;
        12'h343: m_mtval = w;
        default: ;
      endcase
    end
    if (trap_en) begin
      m_mepc = trap_pc; m_mcause = trap_cause; m_mtval = trap_val;
      m_mpie = old_mie; m_mie = 0;
    end else if (mret_en) begin
      m_mie = old_mpie; m_mpie = 1;
    end
  endtask

  // Every rising edge goes through here so the model stays in lock-step.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic drive(input logic [11:0] a, input logic we, input logic [31:0] wd);
    bus.csr_addr = a; bus.csr_we = we; bus.csr_w_data = wd;
    #1;
  endtask

  task automatic idle();
    instret_inc = 0; trap_en = 0; mret_en = 0;
    trap_cause = 0; trap_pc = 0; trap_val = 0;
    drive(12'h340, 1'b0, 32'h0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    #20;
    drive(12'h300, 0, 0);
    checks++;
    if (bus.csr_r_data !== 32'h1800) $display("FAIL reset_mstatus got %h want %h", bus.csr_r_data, 32'h1800);
    else passes++;
    drive(12'hB00, 0, 0);
    checks++;
    if (bus.csr_r_data !== 32'h0) $display("FAIL reset_mcycle got %h want 0", bus.csr_r_data);
    else passes++;
    checks++;
    if (trap_vector !== 32'h0 || epc !== 32'h0 || irq_enable !== 1'b0)
      $display("FAIL reset_outputs got tv=%h epc=%h ie=%b want 0", trap_vector, epc, irq_enable);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick();
    drive(12'hB00, 0, 0);
    checks++;
    if (bus.csr_r_data !== 32'h1) $display("FAIL first_increment got %h want 1", bus.csr_r_data);
    else passes++;
  endtask

  task automatic test_mscratch();
    drive(12'h340, 1, 32'hDEAD_BEEF);
    tick();
    drive(12'h340, 0, 0);
    checks++;
    if (bus.csr_r_data !== 32'hDEAD_BEEF || bus.illegal_csr !== 1'b0)
      $display("FAIL mscratch_rw got %h/%b want deadbeef/0", bus.csr_r_data, bus.illegal_csr);
    else passes++;
  endtask

  task automatic test_trap_mret();
    drive(12'h300, 1, 32'h8);
    tick();
    drive(12'h300, 0, 0);
    checks++;
    if (bus.csr_r_data !== 32'h1808 || irq_enable !== 1'b1)
      $display("FAIL mstatus_write got %h ie=%b want 1808 ie=1", bus.csr_r_data, irq_enable);
    else passes++;
    trap_en = 1; trap_cause = 32'hB; trap_pc = 32'h104; trap_val = 32'h55;
    tick();
    trap_en = 0;
    drive(12'h341, 0, 0);
    checks++;
    if (bus.csr_r_data !== 32'h104 || epc !== 32'h104)
      $display("FAIL trap_mepc got %h epc=%h want 104", bus.csr_r_data, epc);
    else passes++;
    drive(12'h342, 0, 0);
    checks++;
    if (bus.csr_r_data !== 32'hB) $display("FAIL trap_mcause got %h want b", bus.csr_r_data);
    else passes++;
    drive(12'h300, 0, 0);
    checks++;
    if (bus.csr_r_data !== 32'h1880 || irq_enable !== 1'b0)
      $display("FAIL trap_mstatus got %h ie=%b want 1880 ie=0", bus.csr_r_data, irq_enable);
    else passes++;
    mret_en = 1;
    tick();
    mret_en = 0;
    drive(12'h300, 0, 0);
    checks++;
    if (bus.csr_r_data !== 32'h1888 || irq_enable !== 1'b1)
      $display("FAIL mret_mstatus got %h ie=%b want 1888 ie=1", bus.csr_r_data, irq_enable);
    else passes++;
  endtask

  task automatic test_instret_carry();
    drive(12'hB02, 1, 32'hFFFF_FFFF);
    tick();
    drive(12'hB82, 1, 32'h0);
    tick();
    drive(12'hB02, 0, 0);
    instret_inc = 1;
    tick();
    instret_inc = 0;
    drive(12'hB82, 0, 0);
    checks++;
    if (bus.csr_r_data !== 32'h1) $display("FAIL carry_hi got %h want 1", bus.csr_r_data);
    else passes++;
    drive(12'hB02, 0, 0);
    checks++;
    if (bus.csr_r_data !== 32'h0) $display("FAIL carry_lo got %h want 0", bus.csr_r_data);
    else passes++;
    drive(12'hC82, 0, 0);
    checks++;
    if (bus.csr_r_data !== 32'h1) $display("FAIL instreth_shadow got %h want 1", bus.csr_r_data);
    else passes++;
  endtask

  task automatic test_illegal();
    drive(12'hC00, 1, 32'hFFFF_FFFF);
    checks++;
    if (bus.illegal_csr !== 1'b1) $display("FAIL ro_write_flag got %b want 1", bus.illegal_csr);
    else passes++;
    tick();
    drive(12'h7FF, 1, 32'h1234_5678);
    checks++;
    if (bus.illegal_csr !== 1'b1 || bus.csr_r_data !== 32'h0)
      $display("FAIL unknown_addr got %b/%h want 1/0", bus.illegal_csr, bus.csr_r_data);
    else passes++;
    tick();
    drive(12'hB00, 0, 0);
    checks++;
    if (bus.csr_r_data !== m_read(12'hB00))
      $display("FAIL ro_no_effect got %h want %h", bus.csr_r_data, m_read(12'hB00));
    else passes++;
    drive(12'h340, 0, 0);
    checks++;
    if (bus.csr_r_data !== 32'hDEAD_BEEF) $display("FAIL illegal_no_effect got %h want deadbeef", bus.csr_r_data);
    else passes++;
    drive(12'hF14, 0, 0);
    checks++;
    if (bus.csr_r_data !== TB_HART || bus.illegal_csr !== 1'b0)
      $display("FAIL mhartid got %h/%b want %h/0", bus.csr_r_data, bus.illegal_csr, TB_HART);
    else passes++;
    drive(12'h301, 0, 0);
    checks++;
    if (bus.csr_r_data !== TB_MISA) $display("FAIL misa got %h want %h", bus.csr_r_data, TB_MISA);
    else passes++;
  endtask

  task automatic test_priority();
    trap_en = 1; trap_cause = 32'h2; trap_pc = 32'h308; trap_val = 32'h0;
    drive(12'h341, 1, 32'h200);
    tick();
    drive(12'h341, 0, 0);
    checks++;
    if (bus.csr_r_data !== 32'h308) $display("FAIL trap_beats_mepc_write got %h want 308", bus.csr_r_data);
    else passes++;
    trap_pc = 32'h400;
    drive(12'h340, 1, 32'h1234_5678);
    tick();
    trap_en = 0;
    drive(12'h340, 0, 0);
    checks++;
    if (bus.csr_r_data !== 32'h1234_5678) $display("FAIL unrelated_write_commits got %h want 12345678", bus.csr_r_data);
    else passes++;
    checks++;
    if (epc !== 32'h400) $display("FAIL second_trap_epc got %h want 400", epc);
    else passes++;
    mret_en = 1;
    drive(12'h300, 1, 32'h0);
    tick();
    mret_en = 0;
    drive(12'h300, 0, 0);
    checks++;
    if (bus.csr_r_data !== m_read(12'h300))
      $display("FAIL mret_beats_mstatus_write got %h want %h", bus.csr_r_data, m_read(12'h300));
    else passes++;
  endtask

  task automatic test_random();
    logic [11:0] a;
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 9) < 8) ? known_list[$urandom_range(0, 16)] : 12'($urandom);
      instret_inc = 1'($urandom);
      trap_en = ($urandom_range(0, 15) == 0);
      mret_en = ($urandom_range(0, 15) == 0);
      trap_cause = $urandom; trap_pc = $urandom; trap_val = $urandom;
      drive(a, $urandom_range(0, 2) == 0, $urandom);
      checks++;
      if (bus.csr_r_data !== m_read(a) || bus.illegal_csr !== m_illegal(a, bus.csr_we))
        $display("FAIL rand_read addr=%h we=%b got %h/%b want %h/%b", a, bus.csr_we,
                 bus.csr_r_data, bus.illegal_csr, m_read(a), m_illegal(a, bus.csr_we));
      else passes++;
      checks++;
      if (trap_vector !== (m_mtvec & 32'hFFFF_FFFC) || epc !== (m_mepc & 32'hFFFF_FFFC) ||
          irq_enable !== m_mie)
        $display("FAIL rand_outputs got tv=%h epc=%h ie=%b want %h %h %b", trap_vector, epc,
                 irq_enable, m_mtvec & 32'hFFFF_FFFC, m_mepc & 32'hFFFF_FFFC, m_mie);
      else passes++;
      tick();
    end
    idle();
  endtask

  task automatic test_async_reset();
    drive(12'h305, 1, 32'h0000_1003);
    tick();
    drive(12'h300, 1, 32'h8);
    tick();
    drive(12'hB80, 1, 32'h0);
    tick();
    drive(12'hB00, 1, 32'h1234);
    tick();
    drive(12'hB00, 0, 0);
    checks++;
    if (bus.csr_r_data !== 32'h1234) $display("FAIL pre_reset_mcycle got %h want 1234", bus.csr_r_data);
    else passes++;
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.csr_r_data !== 32'h0) $display("FAIL async_reset_mcycle got %h want 0", bus.csr_r_data);
    else passes++;
    checks++;
    if (trap_vector !== 32'h0 || epc !== 32'h0 || irq_enable !== 1'b0)
      $display("FAIL async_reset_outputs got tv=%h epc=%h ie=%b want 0", trap_vector, epc, irq_enable);
    else passes++;
    drive(12'h340, 0, 0);
    checks++;
    if (bus.csr_r_data !== 32'h0) $display("FAIL async_reset_mscratch got %h want 0", bus.csr_r_data);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick();
  endtask

  initial begin
    test_reset();
    test_mscratch();
    test_trap_mret();
    test_instret_carry();
    test_illegal();
    test_priority();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
